// File: rtl/weight_bram_reader.sv
// Read-side sequencer for a single per-neuron weight BRAM. On start it fetches a run of
// consecutive weights (wrapping at the end of the BRAM) and streams them one at a time
// over a valid/ready interface. The BRAM is read-only from this block.
module weight_bram_reader #(
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_do,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last,
  output logic [ADDR_W:0]   w_index
);

  localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] One    = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StOut, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                w_valid_q, w_valid_d;
  logic                w_last_q, w_last_d;
  logic [ADDR_W:0]     w_index_q, w_index_d;

  logic [ADDR_W:0]     count_clamp;
  logic [ADDR_W:0]     base_sub;
  logic [ADDR_W-1:0]   base_mod;
  logic [ADDR_W:0]     addr_inc;
  logic [ADDR_W-1:0]   addr_next;

  // Clamp the requested length, fold an out-of-range base, and advance the address with wrap.
  always_comb begin
    count_clamp = (count > DepthW) ? DepthW : count;
    // Top bit of the difference is the borrow: set when base < DEPTH.
    base_sub    = {1'b0, base} - DepthW;
    base_mod    = base_sub[ADDR_W] ? base : base_sub[ADDR_W-1:0];
    addr_inc    = {1'b0, addr_q} + One;
    addr_next   = (addr_inc >= DepthW) ? '0 : addr_inc[ADDR_W-1:0];
  end

  // Sequencer next-state: abort overrides everything outside idle, including a handshake.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_data_d  = w_data_q;
    w_valid_d = w_valid_q;
    w_last_d  = w_last_q;
    w_index_d = w_index_q;

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      w_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            busy_d  = 1'b1;
            rem_d   = count_clamp;
            idx_d   = '0;
            addr_d  = base_mod;
            state_d = (count_clamp == '0) ? StFin : StIssue;
          end
        end
        StIssue: begin
          // BRAM output settled on the negedge inside this cycle.
          w_data_d  = bram_do;
          w_valid_d = 1'b1;
          w_index_d = idx_q;
          w_last_d  = (rem_q == One);
          state_d   = StOut;
        end
        StOut: begin
          if (w_ready) begin
            w_valid_d = 1'b0;
            if (w_last_q) begin
              state_d = StFin;
            end else begin
              idx_d   = idx_q + One;
              rem_d   = rem_q - One;
              addr_d  = addr_next;
              state_d = StIssue;
            end
          end
        end
        StFin: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers; reset clears the stream immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_data_q  <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      w_index_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_data_q  <= w_data_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      w_index_q <= w_index_d;
    end
  end

  assign bram_en   = (state_q == StIssue);
  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign w_data    = w_data_q;
  assign w_valid   = w_valid_q;
  assign w_last    = w_last_q;
  assign w_index   = w_index_q;

endmodule

// File: tb/tb_weight_bram_reader.sv
// Bench for weight_bram_reader: a negedge-read BRAM model plus directed and randomized fetches
// compared against a simple arithmetic model of which words a fetch should deliver.
module tb_weight_bram_reader;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy, done, bram_en, bram_we, w_valid, w_last;
  logic              w_ready = 1'b0;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_do = '0;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W:0]   w_index;

  logic [DATA_W-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, first_valid_cyc, done_cyc, done_pulses;
  bit timed_out;
  logic [DATA_W-1:0] obs_data [$];
  int obs_idx [$];
  bit obs_last [$];
  int hs_cyc [$];
  int en_addr [$];

  weight_bram_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base(base), .count(count),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_do(bram_do), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_last(w_last), .w_index(w_index)
  );

  always #5 clk = ~clk;

  // BRAM updates its output on the falling edge while enabled.
  always @(negedge clk) if (bram_en) bram_do <= mem[bram_addr];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: word k of a fetch and its effective length.
  function automatic logic [DATA_W-1:0] exp_word(input int b, input int k);
    return mem[((b % DEPTH) + k) % DEPTH];
  endfunction
  function automatic int exp_len(input int c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  task automatic tick;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic fill_pattern;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + 16'(i);
  endtask

  task automatic fill_random;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  task automatic clear_obs;
    obs_data.delete(); obs_idx.delete(); obs_last.delete(); hs_cyc.delete(); en_addr.delete();
    first_valid_cyc = -1; done_cyc = -1; done_pulses = 0; timed_out = 0;
  endtask

  task automatic do_start(input int b, input int c);
    base = b[ADDR_W-1:0]; count = c[ADDR_W:0]; start = 1'b1;
    tick();
    start = 1'b0; start_cyc = cyc;
  endtask

  // Drive ready with the given percentage and record handshakes until done or the limit.
  task automatic collect(input int ready_pct, input int limit);
    int n = 0;
    while (done_cyc < 0 && n < limit) begin
      w_ready = ($urandom_range(99) < ready_pct);
      if (bram_en) en_addr.push_back(int'(bram_addr));
      if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (w_valid && w_ready) begin
        obs_data.push_back(w_data); obs_idx.push_back(int'(w_index));
        obs_last.push_back(w_last); hs_cyc.push_back(cyc + 1);
      end
      tick(); n++;
      if (done === 1'b1) begin done_cyc = cyc; done_pulses++; end
    end
    w_ready = 1'b0;
    if (done_cyc < 0) timed_out = 1;
    tick();
    if (done === 1'b1) done_pulses++;
  endtask

  task automatic test_reset;
    int bad = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, bram_en, bram_we, bram_addr, w_data, w_valid, w_last, w_index} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b we=%b addr=%h data=%h v=%b l=%b idx=%h want all 0",
               busy, done, bram_en, bram_we, bram_addr, w_data, w_valid, w_last, w_index);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    // start and abort together in idle: the start must not be accepted
    base = 5'd3; count = 6'd5; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || w_valid !== 1'b0 || bram_en !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL start_abort_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_full_sweep;
    int bad_sp = 0;
    fill_pattern();
    clear_obs();
    do_start(0, 28);
    collect(100, 200);
    n_cmp++;
    if (timed_out || obs_data.size() != 28) begin
      n_err++;
      $display("FAIL sweep_len: got %0d words timeout=%0b want 28", obs_data.size(), timed_out);
    end
    for (int k = 0; k < obs_data.size() && k < 28; k++) begin
      n_cmp++;
      if (obs_data[k] !== 16'h0100 + 16'(k) || obs_idx[k] != k || obs_last[k] != (k == 27)) begin
        n_err++;
        $display("FAIL sweep_word[%0d]: got data=%h idx=%0d last=%0b want data=%h idx=%0d last=%0b",
                 k, obs_data[k], obs_idx[k], obs_last[k], 16'h0100 + 16'(k), k, (k == 27));
      end
    end
    n_cmp++;
    if (first_valid_cyc != start_cyc + 1) begin
      n_err++;
      $display("FAIL sweep_latency: got first valid at %0d want %0d", first_valid_cyc, start_cyc + 1);
    end
    for (int k = 1; k < hs_cyc.size(); k++) if (hs_cyc[k] - hs_cyc[k-1] != 2) bad_sp++;
    n_cmp++;
    if (bad_sp != 0) begin
      n_err++;
      $display("FAIL sweep_throughput: got %0d gaps not equal to 2 cycles want 0", bad_sp);
    end
    n_cmp++;
    if (hs_cyc.size() == 0 || done_cyc != hs_cyc[$] + 1 || done_pulses != 1) begin
      n_err++;
      $display("FAIL sweep_done: got done at %0d pulses=%0d want one pulse at %0d", done_cyc,
               done_pulses, (hs_cyc.size() == 0) ? -1 : hs_cyc[$] + 1);
    end
    n_cmp++;
    if (en_addr.size() != 28 || en_addr[0] != 0 || en_addr[$] != 27) begin
      n_err++;
      $display("FAIL sweep_bram_en: got %0d enable cycles want 28 over addresses 0..27",
               en_addr.size());
    end
  endtask

  task automatic test_wrap;
    logic [DATA_W-1:0] want [4];
    int want_addr [4];
    want[0] = 16'h011A; want[1] = 16'h011B; want[2] = 16'h0100; want[3] = 16'h0101;
    want_addr[0] = 26; want_addr[1] = 27; want_addr[2] = 0; want_addr[3] = 1;
    fill_pattern();
    clear_obs();
    do_start(26, 4);
    collect(100, 40);
    n_cmp++;
    if (timed_out || obs_data.size() != 4 || en_addr.size() != 4) begin
      n_err++;
      $display("FAIL wrap_len: got %0d words %0d reads want 4", obs_data.size(), en_addr.size());
    end
    for (int k = 0; k < obs_data.size() && k < 4 && k < en_addr.size(); k++) begin
      n_cmp++;
      if (obs_data[k] !== want[k] || obs_idx[k] != k || obs_last[k] != (k == 3) ||
          en_addr[k] != want_addr[k]) begin
        n_err++;
        $display("FAIL wrap_word[%0d]: got data=%h idx=%0d last=%0b addr=%0d want %h %0d %0b %0d",
                 k, obs_data[k], obs_idx[k], obs_last[k], en_addr[k], want[k], k, (k == 3),
                 want_addr[k]);
      end
    end
  endtask

  task automatic test_stall;
    int n = 0;
    int bad = 0;
    logic [DATA_W-1:0] held_data;
    logic [ADDR_W:0] held_idx;
    fill_pattern();
    clear_obs();
    do_start(5, 6);
    while (!(w_valid === 1'b1 && w_index == 6'd2) && n < 40) begin
      w_ready = 1'b1; tick(); n++;
    end
    w_ready = 1'b0;
    held_data = w_data; held_idx = w_index;
    n_cmp++;
    if (w_valid !== 1'b1 || held_data !== exp_word(5, 2)) begin
      n_err++;
      $display("FAIL stall_word: got valid=%b data=%h want valid=1 data=%h", w_valid, held_data,
               exp_word(5, 2));
    end
    repeat (5) begin
      tick();
      if (w_valid !== 1'b1 || w_data !== held_data || w_index !== held_idx || bram_en !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
    end
    w_ready = 1'b1;
    tick();
    n_cmp++;
    if (w_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: got valid=%b want 0", w_valid);
    end
    collect(100, 40);
    n_cmp++;
    if (timed_out || obs_idx.size() != 3 || obs_idx[0] != 3 || obs_data[2] !== exp_word(5, 5) ||
        obs_last[2] != 1'b1) begin
      n_err++;
      $display("FAIL stall_tail: got %0d words timeout=%0b want words 3..5 ending in last",
               obs_idx.size(), timed_out);
    end
  endtask

  task automatic test_count_zero;
    int bad = 0;
    fill_pattern();
    clear_obs();
    do_start(9, 0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_busy: got busy=%b want 1", busy);
    end
    collect(100, 10);
    n_cmp++;
    if (obs_data.size() != 0 || en_addr.size() != 0 || done_cyc != start_cyc + 1 ||
        done_pulses != 1) begin
      n_err++;
      $display("FAIL zero_fetch: got words=%0d reads=%0d done_at=%0d pulses=%0d want 0 0 %0d 1",
               obs_data.size(), en_addr.size(), done_cyc, done_pulses, start_cyc + 1);
    end
    // A second start while busy must not restart or extend the fetch.
    clear_obs();
    do_start(2, 4);
    base = 5'd20; count = 6'd10; start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    collect(100, 40);
    n_cmp++;
    if (timed_out || obs_data.size() != 4 || obs_data[0] !== exp_word(2, 0) ||
        obs_data[3] !== exp_word(2, 3)) begin
      n_err++;
      $display("FAIL start_while_busy: got %0d words first=%h want 4 words first=%h",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx, exp_word(2, 0));
    end
    repeat (4) begin
      if (w_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL start_while_busy_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_abort;
    int n = 0;
    int bad = 0;
    fill_random();
    clear_obs();
    do_start(10, 8);
    while (!(w_valid === 1'b1 && w_index == 6'd3) && n < 40) begin
      w_ready = 1'b1; tick(); n++;
    end
    abort = 1'b1; w_ready = 1'b1;
    tick();
    abort = 1'b0; w_ready = 1'b0;
    n_cmp++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: got valid=%b busy=%b done=%b want 0 0 0", w_valid, busy, done);
    end
    repeat (4) begin
      tick();
      if (done !== 1'b0 || w_valid !== 1'b0 || bram_en !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
    end
    clear_obs();
    do_start(20, 3);
    collect(100, 40);
    n_cmp++;
    if (timed_out || obs_data.size() != 3 || obs_data[0] !== exp_word(20, 0) ||
        obs_data[2] !== exp_word(20, 2) || obs_idx[0] != 0 || done_pulses != 1) begin
      n_err++;
      $display("FAIL abort_restart: got %0d words first=%h want 3 words first=%h",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx, exp_word(20, 0));
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    fill_random();
    clear_obs();
    do_start(15, 5);
    w_ready = 1'b0;
    while (w_valid !== 1'b1 && n < 5) begin tick(); n++; end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bram_en, bram_addr, w_data, w_valid, w_last, w_index} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b v=%b data=%h idx=%h addr=%h want all 0",
               busy, w_valid, w_data, w_index, bram_addr);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_idle: got busy=%b done=%b valid=%b want 0 0 0", busy, done,
               w_valid);
    end
    clear_obs();
    do_start(0, 3);
    collect(100, 40);
    n_cmp++;
    if (timed_out || obs_data.size() != 3 || obs_data[0] !== exp_word(0, 0) || obs_idx[2] != 2 ||
        obs_last[2] != 1'b1 || first_valid_cyc != start_cyc + 1) begin
      n_err++;
      $display("FAIL async_reset_cold: got %0d words first=%h want 3 words first=%h",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx, exp_word(0, 0));
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 14; it++) begin
      int b, c, len, pct, bad;
      b = $urandom_range(31); c = $urandom_range(40); pct = $urandom_range(100, 30);
      len = exp_len(c); bad = 0;
      fill_random();
      clear_obs();
      do_start(b, c);
      collect(pct, 800);
      if (timed_out || obs_data.size() != len || en_addr.size() != len) bad++;
      for (int k = 0; k < obs_data.size() && k < len && k < en_addr.size(); k++) begin
        if (obs_data[k] !== exp_word(b, k) || obs_idx[k] != k || obs_last[k] != (k == len - 1) ||
            en_addr[k] != ((b % DEPTH) + k) % DEPTH) bad++;
      end
      if (len > 0 && hs_cyc.size() > 0 && done_cyc != hs_cyc[$] + 1) bad++;
      if (len == 0 && done_cyc != start_cyc + 1) bad++;
      if (done_pulses != 1) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL random[%0d] base=%0d count=%0d: got %0d words %0d errors want %0d words 0 errors",
                 it, b, c, obs_data.size(), bad, len);
      end
    end
  endtask

  initial begin
    fill_pattern();
    test_reset();
    test_full_sweep();
    test_wrap();
    test_stall();
    test_count_zero();
    test_abort();
    test_async_reset();
    test_random();
    n_cmp++;
    if (bram_we !== 1'b0) begin
      n_err++;
      $display("FAIL bram_we: got %b want 0", bram_we);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
